input_event_queue: RTL and testbench
====================================

# input_event_queue

Parametrised successor to the single-purpose button FIFO feeding the CPU. It watches `WIDTH` debounced input levels, detects rising and/or falling edges per channel under run-time enable masks, and tags each event with channel index, edge type and a free-running timestamp. Simultaneous events are serialised through a pending register, and the events are queued in a `DEPTH`-entry FIFO that the CPU drains through the usual `rd_en`/`dout`/`empty` MMIO path. Lost events are counted, not silently dropped.

## Interface
- `WIDTH`, 4: number of input channels, 1..256
- `DEPTH`, 8: FIFO entries, power of two, ≥2
- `TS_WIDTH`, 16: timestamp counter width, 1..16
- `clk` input 1: single clock (cpu_clk domain)
- `rst` input 1: reset, asynchronous, active-low (asserted at 0)
- `in` input WIDTH: debounced, already-synchronous input levels
- `rise_en` input WIDTH: per-channel rising-edge enable
- `fall_en` input WIDTH: per-channel falling-edge enable
- `rd_en` input 1: pop request from CPU
- `clr_overflow` input 1: synchronous clear of `overflow_cnt`
- `dout` output 32: last popped event word
- `empty` output 1: FIFO holds no entries
- `full` output 1: FIFO holds DEPTH entries
- `count` output $clog2(DEPTH)+1: current occupancy
- `overflow_cnt` output 16: saturating lost-event counter

## Operation
- Event word: [31:16] timestamp, zero-extended to 16 bits; [15] edge (1 = rise, 0 = fall); [14:8] 0; [7:0] channel index.
- `in_q` holds the previous `in`. `arm` is 0 after reset. On the first clock after reset release, `in_q` loads `in` and `arm` goes to 1. No edges are generated on that cycle.
- Edge detection, gated by `arm`: `new_rise = in & ~in_q & rise_en`; `new_fall = ~in & in_q & fall_en`.
- Pending registers `pend_rise`/`pend_fall` (WIDTH each) collect new edges. Each cycle, select = pending OR new.
- Arbitration:
  - The lowest channel index wins.
  - Within one channel, a rise is granted before a fall.
  - One event is pushed per cycle.
- The granted bit is cleared. All other selected bits stay pending.
- Push is allowed when `!full`, or when `full && rd_en` (simultaneous pop frees the slot).
- If push is blocked, all selected bits stay pending.
- Coalescing: a new edge whose pending bit is already set is lost. `overflow_cnt` increments by 1 per cycle in which any coalescing occurs, and saturates at 16'hFFFF.
- The timestamp is the `ts` counter value at the push cycle, not the detection cycle.
- `ts` increments every cycle and wraps modulo 2^TS_WIDTH.
- `clr_overflow` takes priority over an increment in the same cycle. The result is 0.
- Pop: `rd_en && !empty` removes the head and loads it into `dout`. `rd_en` while empty is ignored, and `dout` holds its value.
- Reset mid-operation: all state is discarded immediately, including FIFO contents, pending bits, `ts`, `arm` and the counter.

## Timing
- Reset values:
  - `dout` = 0, `empty` = 1, `full` = 0, `count` = 0, `overflow_cnt` = 0
  - `ts` = 0, `in_q` = 0, pending = 0, `arm` = 0
- Edge-to-queue latency: `in` changes before clock edge t, and the event is written at edge t if it wins arbitration. `empty`/`count` reflect it after edge t.
- Pop latency: with `rd_en` high at edge t, the new `dout` is valid after edge t and held until the next pop.
- `count`, `empty` and `full` are registered. Simultaneous push and pop leaves `count` unchanged.
- Pointers wrap modulo DEPTH. Occupancy is tracked with the extra `count` MSB.

## Structure
- Package `input_event_pkg`: event-word field offsets, `EDGE_RISE = 1'b1` / `EDGE_FALL = 1'b0`, `OVF_MAX = 16'hFFFF`.
- Sub-module `event_ring`: parametrised synchronous circular buffer (WIDTH 32, DEPTH), with registered read, count, full and empty. Edge detection, pending and arbitration logic, timestamp and overflow counter live in the top of the block.

## Test plan
- Reset with `in` = 4'b1111, then release: no events, `empty` = 1 for 20 cycles.
- `rise_en` = 4'b0001, pulse `in[0]` high: one word, with ch 0 and edge 1 and ts = push-cycle `ts`. `fall_en` = 0, so the fall is not queued.
- Channels 3, 1 and 0 all rise in one cycle: the words pop in order ch0, ch1, ch3 with consecutive timestamps, and `overflow_cnt` = 0.
- Fill with 8 events without popping, then toggle `in[2]` twice more: `full` = 1, one pending kept, `overflow_cnt` = 1. After popping once, the pending event enters and `count` stays 8.
- At `full`, assert `rd_en` with a new edge in the same cycle: the push succeeds, `count` = 8, `overflow_cnt` unchanged.
- Assert `rst` = 0 with 5 entries queued and pending bits set: `empty` = 1, `count` = 0, `dout` = 0 immediately, with no events after release until a new edge.

Source files
------------

// File: rtl/input_event_pkg.sv
// rtl/input_event_pkg.sv - shared event-word layout and constants for the input event queue
package input_event_pkg;

    localparam int TS_LSB   = 16;
    localparam int TS_MSB   = 31;
    localparam int EDGE_BIT = 15;
    localparam int CH_LSB   = 0;
    localparam int CH_MSB   = 7;

    localparam logic        EDGE_RISE = 1'b1;
    localparam logic        EDGE_FALL = 1'b0;
    localparam logic [15:0] OVF_MAX   = 16'hFFFF;

    function automatic logic [31:0] make_event(input logic [15:0] ts,
                                               input logic        edge_type,
                                               input logic [7:0]  ch);
        logic [31:0] w;
        w                 = '0;
        w[TS_MSB:TS_LSB]  = ts;
        w[EDGE_BIT]       = edge_type;
        w[CH_MSB:CH_LSB]  = ch;
        return w;
    endfunction

endpackage

// File: rtl/event_ring.sv
// rtl/event_ring.sv - synchronous circular buffer with registered read, count, full and empty
module event_ring #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_n;
    logic             do_wr;
    logic             do_rd;

    // A write into a full ring is legal only when the same cycle pops the head.
    always_comb begin
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        count_n = count;
        case ({do_wr, do_rd})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/input_event_queue.sv
// rtl/input_event_queue.sv - per-channel edge detector feeding a timestamped event FIFO
module input_event_queue
    import input_event_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in,
    input  logic [WIDTH-1:0]       rise_en,
    input  logic [WIDTH-1:0]       fall_en,
    input  logic                   rd_en,
    input  logic                   clr_overflow,
    output logic [31:0]            dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            overflow_cnt
);
    logic [WIDTH-1:0]    in_q;
    logic                arm;
    logic [WIDTH-1:0]    pend_rise;
    logic [WIDTH-1:0]    pend_fall;
    logic [TS_WIDTH-1:0] ts;

    logic [WIDTH-1:0]    new_rise;
    logic [WIDTH-1:0]    new_fall;
    logic [WIDTH-1:0]    sel_rise;
    logic [WIDTH-1:0]    sel_fall;
    logic [WIDTH-1:0]    grant_vec;
    logic [7:0]          grant_ch;
    logic                grant_edge;
    logic                coalesce;
    logic                push;
    logic [31:0]         push_word;

    always_comb begin
        new_rise   = arm ? (in & ~in_q & rise_en) : '0;
        new_fall   = arm ? (~in & in_q & fall_en) : '0;
        sel_rise   = pend_rise | new_rise;
        sel_fall   = pend_fall | new_fall;
        coalesce   = |(new_rise & pend_rise) || |(new_fall & pend_fall);
        grant_vec  = '0;
        grant_ch   = '0;
        grant_edge = EDGE_FALL;
        // Walk from the top so the lowest active channel is the last (winning) assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sel_rise[i] || sel_fall[i]) begin
                grant_vec    = '0;
                grant_vec[i] = 1'b1;
                grant_ch     = 8'(i);
                grant_edge   = sel_rise[i] ? EDGE_RISE : EDGE_FALL;
            end
        end
        push      = (|(sel_rise | sel_fall)) && (!full || rd_en);
        push_word = make_event(16'(ts), grant_edge, grant_ch);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q         <= '0;
            arm          <= 1'b0;
            pend_rise    <= '0;
            pend_fall    <= '0;
            ts           <= '0;
            overflow_cnt <= '0;
        end else begin
            in_q      <= in;
            arm       <= 1'b1;
            ts        <= ts + TS_WIDTH'(1);
            pend_rise <= sel_rise & ~((push && grant_edge == EDGE_RISE) ? grant_vec : '0);
            pend_fall <= sel_fall & ~((push && grant_edge == EDGE_FALL) ? grant_vec : '0);
            if (clr_overflow) begin
                overflow_cnt <= '0;
            end else if (coalesce && overflow_cnt != OVF_MAX) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    event_ring #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (rd_en),
        .rd_data (dout),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_input_event_queue.sv
// tb/tb_input_event_queue.sv - self-checking bench for input_event_queue
module tb_input_event_queue;
    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int TS_W  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_s, rise_s, fall_s;
    logic          rd_s, clr_s;
    logic [31:0]   dout;
    logic          empty, full;
    logic [3:0]    count;
    logic [15:0]   overflow_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_event_queue #(.WIDTH(W), .DEPTH(DEPTH), .TS_WIDTH(TS_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in_s),
        .rise_en      (rise_s),
        .fall_en      (fall_s),
        .rd_en        (rd_s),
        .clr_overflow (clr_s),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow_cnt (overflow_cnt)
    );

    // Reference model: event list as a queue, pending edges as plain bit sets.
    logic [31:0]  m_q[$];
    logic [31:0]  m_dout;
    int           m_ts, m_ovf;
    logic [W-1:0] m_inq, m_pr, m_pf;
    logic         m_arm;

    task automatic model_reset();
        m_q.delete();
        m_dout = 0; m_ts = 0; m_ovf = 0;
        m_inq = 0; m_pr = 0; m_pf = 0; m_arm = 0;
    endtask

    task automatic model_step(input logic [W-1:0] i, re, fe, input logic rd, clr);
        logic [W-1:0] nr, nf, sr, sf;
        logic         pushed;
        logic [31:0]  word;
        nr = m_arm ? (i & ~m_inq & re) : '0;
        nf = m_arm ? (~i & m_inq & fe) : '0;
        sr = m_pr | nr;
        sf = m_pf | nf;
        pushed = 1'b0;
        word = 0;
        if (m_q.size() < DEPTH || rd) begin
            for (int ch = 0; ch < W && !pushed; ch++) begin
                if (sr[ch]) begin
                    word = {16'(m_ts), 1'b1, 7'd0, 8'(ch)};
                    sr[ch] = 1'b0;
                    pushed = 1'b1;
                end else if (sf[ch]) begin
                    word = {16'(m_ts), 1'b0, 7'd0, 8'(ch)};
                    sf[ch] = 1'b0;
                    pushed = 1'b1;
                end
            end
        end
        if (rd && m_q.size() > 0) m_dout = m_q.pop_front();
        if (pushed) m_q.push_back(word);
        if (clr) m_ovf = 0;
        else if (((nr & m_pr) | (nf & m_pf)) != 0 && m_ovf < 65535) m_ovf = m_ovf + 1;
        m_pr = sr; m_pf = sf; m_inq = i; m_arm = 1'b1;
        m_ts = (m_ts + 1) % (1 << TS_W);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("dout", dout, m_dout);
        check("ovf", 32'(overflow_cnt), 32'(m_ovf));
    endtask

    task automatic step(input logic [W-1:0] i, re, fe, input logic rd, clr);
        in_s = i; rise_s = re; fall_s = fe; rd_s = rd; clr_s = clr;
        model_step(i, re, fe, rd, clr);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    typedef struct {
        logic [W-1:0] in_v;
        logic [W-1:0] re;
        logic [W-1:0] fe;
        logic         rd;
        logic [3:0]   exp_cnt;
        logic [15:0]  exp_lo;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 4'd1, 16'h0000};
        tbl[1]  = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 4'd1, 16'h0000};
        tbl[2]  = '{4'b0000, 4'b0001, 4'b0000, 1'b1, 4'd0, 16'h8000};
        tbl[3]  = '{4'b1011, 4'b1111, 4'b0000, 1'b0, 4'd1, 16'h8000};
        tbl[4]  = '{4'b1011, 4'b1111, 4'b0000, 1'b0, 4'd2, 16'h8000};
        tbl[5]  = '{4'b1011, 4'b1111, 4'b0000, 1'b0, 4'd3, 16'h8000};
        tbl[6]  = '{4'b1011, 4'b1111, 4'b0000, 1'b1, 4'd2, 16'h8000};
        tbl[7]  = '{4'b1011, 4'b1111, 4'b0000, 1'b1, 4'd1, 16'h8001};
        tbl[8]  = '{4'b1011, 4'b1111, 4'b0000, 1'b1, 4'd0, 16'h8003};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b1111, 1'b0, 4'd1, 16'h8003};
        tbl[10] = '{4'b0000, 4'b0000, 4'b1111, 1'b0, 4'd2, 16'h8003};
        tbl[11] = '{4'b0000, 4'b0000, 4'b1111, 1'b0, 4'd3, 16'h8003};
        tbl[12] = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 4'd2, 16'h0000};
        tbl[13] = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 4'd1, 16'h0001};
        tbl[14] = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 4'd0, 16'h0003};
        tbl[15] = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 4'd0, 16'h0003};

        rst = 1'b0; in_s = 4'b1111; rise_s = 4'b1111; fall_s = 4'b1111; rd_s = 0; clr_s = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        rst = 1'b1;

        repeat (20) step(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0);
        check("idle_empty", 32'(empty), 32'd1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        foreach (tbl[k]) begin
            step(tbl[k].in_v, tbl[k].re, tbl[k].fe, tbl[k].rd, 1'b0);
            check($sformatf("tbl%0d_cnt", k), 32'(count), 32'(tbl[k].exp_cnt));
            check($sformatf("tbl%0d_lo", k), 32'(dout[15:0]), 32'(tbl[k].exp_lo));
            check($sformatf("tbl%0d_ovf", k), 32'(overflow_cnt), 32'd0);
        end

        // Fill, then block one rise and coalesce a second one behind it.
        for (int k = 0; k < 8; k++) begin
            step(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
            step(4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
        end
        check("fill_full", 32'(full), 32'd1);
        step(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
        check("coal_ovf", 32'(overflow_cnt), 32'd1);
        check("coal_cnt", 32'(count), 32'd8);
        step(4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0);
        check("pend_enter_cnt", 32'(count), 32'd8);
        check("pend_enter_dout", 32'(dout[15:0]), 32'h8002);
        step(4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
        check("full_rdpush_cnt", 32'(count), 32'd8);
        check("full_rdpush_ovf", 32'(overflow_cnt), 32'd1);
        step(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow_cnt), 32'd0);
        repeat (8) step(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);

        // Reset with queued entries and pending bits.
        step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0);
            step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        end
        step(4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0);
        step(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(count), 32'd5);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_dout", dout, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) step(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0);
        check("post_rst_empty", 32'(empty), 32'd1);

        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
